// File: rtl/regfile_wport_arb_pkg.sv
// Shared register-file defines and the write-port arbiter state encodings.
package regfile_wport_arb_pkg;

    typedef logic [4:0]  RegAddrBus;
    typedef logic [31:0] RegBus;

    localparam RegBus ZeroWord    = 32'h0000_0000;
    localparam logic  WriteEnable = 1'b1;
    localparam logic  RstEnable   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STEAL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/regfile_wport_arb_if.sv
// Requester and register-file write-port signals of the write-port arbiter.
interface regfile_wport_arb_if;
    import regfile_wport_arb_pkg::*;

    // Handshakes: a divider result transfers on a cycle with div_valid && div_ready;
    // a debug write transfers on a cycle with dbg_valid && dbg_ready; wb_we has no
    // ready and is only held off by stall_req. Requests must stay stable until taken.
    logic      wb_we;
    RegAddrBus wb_waddr;
    RegBus     wb_wdata;
    logic      div_valid;
    RegAddrBus div_waddr;
    RegBus     div_wdata;
    logic      div_ready;
    logic      dbg_valid;
    RegAddrBus dbg_waddr;
    RegBus     dbg_wdata;
    logic      dbg_ready;
    logic      we;
    RegAddrBus waddr;
    RegBus     wdata;
    logic      stall_req;
    logic      div_pending;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  div_valid, div_waddr, div_wdata,
        output div_ready,
        input  dbg_valid, dbg_waddr, dbg_wdata,
        output dbg_ready,
        output we, waddr, wdata,
        output stall_req, div_pending
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output div_valid, div_waddr, div_wdata,
        input  div_ready,
        output dbg_valid, dbg_waddr, dbg_wdata,
        input  dbg_ready,
        input  we, waddr, wdata,
        input  stall_req, div_pending
    );

endinterface

// File: rtl/regfile_wport_arb.sv
// Shares the register-file write port between writeback, a buffered divider
// result and debug writes, with a starvation guard that steals one cycle.
module regfile_wport_arb
    import regfile_wport_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    regfile_wport_arb_if.slave                bus,
    output arb_state_t                        state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    RegAddrBus        buf_addr;
    RegBus            buf_data;

    logic      stall, full, accept;
    logic      grant_wb, grant_buf, grant_dbg;
    RegAddrBus sel_addr;
    RegBus     sel_data;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            buf_addr <= '0;
            buf_data <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                buf_addr <= bus.div_waddr;
                buf_data <= bus.div_wdata;
            end
        end
    end

    always_comb begin
        stall     = (state_q == STEAL);
        full      = (state_q != IDLE);
        accept    = !full && bus.div_valid;
        grant_wb  = 1'b0;
        grant_buf = 1'b0;
        grant_dbg = 1'b0;
        // During a steal the pipeline is frozen, so its write is re-presented later.
        if (stall)              grant_buf = 1'b1;
        else if (bus.wb_we)     grant_wb  = 1'b1;
        else if (full)          grant_buf = 1'b1;
        else if (bus.dbg_valid) grant_dbg = 1'b1;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PEND;
            end
            PEND: begin
                if (grant_buf) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LIMIT) state_d = STEAL;
                end
            end
            STEAL: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_addr = '0;
        sel_data = ZeroWord;
        if (grant_wb) begin
            sel_addr = bus.wb_waddr;
            sel_data = bus.wb_wdata;
        end else if (grant_buf) begin
            sel_addr = buf_addr;
            sel_data = buf_data;
        end else if (grant_dbg) begin
            sel_addr = bus.dbg_waddr;
            sel_data = bus.dbg_wdata;
        end
    end

    // Register 0 is hardwired: the grant still consumes the request but no write occurs.
    always_comb begin
        bus.we          = (grant_wb || grant_buf || grant_dbg) && (sel_addr != '0);
        bus.waddr       = sel_addr;
        bus.wdata       = sel_data;
        bus.div_ready   = !full;
        bus.dbg_ready   = grant_dbg;
        bus.stall_req   = stall;
        bus.div_pending = full;
        if (rst == RstEnable) begin
            bus.we          = !WriteEnable;
            bus.waddr       = '0;
            bus.wdata       = ZeroWord;
            bus.div_ready   = 1'b0;
            bus.dbg_ready   = 1'b0;
            bus.stall_req   = 1'b0;
            bus.div_pending = 1'b0;
        end
    end

    assign state      = state_q;
    assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb with STARVE_LIMIT = 4.
module tb_regfile_wport_arb;
    import regfile_wport_arb_pkg::*;

    localparam int LIMIT = 4;

    logic       clk;
    logic       rst;
    arb_state_t state;
    logic [$clog2(LIMIT+1)-1:0] starve_cnt;
    int         checks;
    int         failures;

    regfile_wport_arb_if bus ();

    regfile_wport_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state      (state),
        .starve_cnt (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.wb_we     = 1'b0;
        bus.wb_waddr  = '0;
        bus.wb_wdata  = '0;
        bus.div_valid = 1'b0;
        bus.div_waddr = '0;
        bus.div_wdata = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_waddr = '0;
        bus.dbg_wdata = '0;
    endtask

    task automatic chk_write(input string tag, input logic we_e, input logic [4:0] addr_e,
                             input logic [31:0] data_e);
        chk({tag, "_we"}, 32'(bus.we), 32'(we_e));
        chk({tag, "_waddr"}, 32'(bus.waddr), 32'(addr_e));
        chk({tag, "_wdata"}, bus.wdata, data_e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.wb_we     = 1'b1; bus.wb_waddr  = 5'd1; bus.wb_wdata  = 32'h1111_1111;
        bus.div_valid = 1'b1; bus.div_waddr = 5'd2; bus.div_wdata = 32'h2222_2222;
        bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd3; bus.dbg_wdata = 32'h3333_3333;

        // Reset held for 3 cycles with every request asserted
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_we", 32'(bus.we), 32'd0);
            chk("rst_div_ready", 32'(bus.div_ready), 32'd0);
            chk("rst_dbg_ready", 32'(bus.dbg_ready), 32'd0);
            chk("rst_stall", 32'(bus.stall_req), 32'd0);
        end
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_cnt", 32'(starve_cnt), 32'd0);
        chk("rst_pending", 32'(bus.div_pending), 32'd0);
        chk_write("rst_bus", 1'b0, 5'd0, 32'h0);
        clear_reqs();
        rst = 1'b0;
        cyc();

        // Uncontended divider result
        bus.div_valid = 1'b1; bus.div_waddr = 5'd5; bus.div_wdata = 32'h0000_1234;
        #1;
        chk("div_ready_idle", 32'(bus.div_ready), 32'd1);
        chk("div_no_passthru", 32'(bus.we), 32'd0);
        cyc();
        bus.div_valid = 1'b0;
        #1;
        chk_write("div_write", 1'b1, 5'd5, 32'h0000_1234);
        chk("div_pending_hi", 32'(bus.div_pending), 32'd1);
        chk("div_ready_full", 32'(bus.div_ready), 32'd0);
        cyc();
        chk("div_pending_lo", 32'(bus.div_pending), 32'd0);
        chk("div_done_we", 32'(bus.we), 32'd0);

        // Priority: wb over buffer over debug
        bus.div_valid = 1'b1; bus.div_waddr = 5'd4; bus.div_wdata = 32'h0000_000B;
        cyc();
        bus.div_valid = 1'b0;
        bus.wb_we     = 1'b1; bus.wb_waddr  = 5'd3; bus.wb_wdata  = 32'h0000_000A;
        bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd6; bus.dbg_wdata = 32'h0000_000C;
        #1;
        chk_write("prio_c1", 1'b1, 5'd3, 32'h0000_000A);
        chk("prio_c1_dbg_ready", 32'(bus.dbg_ready), 32'd0);
        cyc();
        bus.wb_we = 1'b0;
        bus.div_valid = 1'b1; bus.div_waddr = 5'd9; bus.div_wdata = 32'h0000_0099;
        #1;
        chk_write("prio_c2", 1'b1, 5'd4, 32'h0000_000B);
        chk("prio_c2_dbg_ready", 32'(bus.dbg_ready), 32'd0);
        chk("drain_div_ready", 32'(bus.div_ready), 32'd0);
        cyc();
        chk_write("prio_c3", 1'b1, 5'd6, 32'h0000_000C);
        chk("prio_c3_dbg_ready", 32'(bus.dbg_ready), 32'd1);
        chk("after_drain_div_ready", 32'(bus.div_ready), 32'd1);
        cyc();
        bus.div_valid = 1'b0;
        bus.dbg_valid = 1'b0;
        #1;
        chk_write("late_div", 1'b1, 5'd9, 32'h0000_0099);
        cyc();

        // Starvation: wb held high against a buffered r7
        bus.div_valid = 1'b1; bus.div_waddr = 5'd7; bus.div_wdata = 32'h0000_0077;
        cyc();
        bus.div_valid = 1'b0;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd8; bus.wb_wdata = 32'h0000_0088;
        for (int i = 0; i < LIMIT; i++) begin
            #1;
            chk("starve_cnt", 32'(starve_cnt), 32'(i));
            chk("starve_stall_lo", 32'(bus.stall_req), 32'd0);
            chk_write("starve_wb", 1'b1, 5'd8, 32'h0000_0088);
            cyc();
        end
        chk("steal_state", 32'(state), 32'(STEAL));
        chk("steal_cnt", 32'(starve_cnt), 32'(LIMIT));
        chk("steal_stall_hi", 32'(bus.stall_req), 32'd1);
        chk_write("steal_write", 1'b1, 5'd7, 32'h0000_0077);
        cyc();
        chk("post_steal_stall", 32'(bus.stall_req), 32'd0);
        chk("post_steal_state", 32'(state), 32'(IDLE));
        chk("post_steal_cnt", 32'(starve_cnt), 32'd0);
        chk_write("wb_represent", 1'b1, 5'd8, 32'h0000_0088);
        cyc();
        bus.wb_we = 1'b0;

        // Register 0 writes are consumed without writing
        bus.div_valid = 1'b1; bus.div_waddr = 5'd0; bus.div_wdata = 32'hFFFF_FFFF;
        #1;
        chk("r0_div_ready", 32'(bus.div_ready), 32'd1);
        cyc();
        bus.div_valid = 1'b0;
        #1;
        chk("r0_div_we", 32'(bus.we), 32'd0);
        chk("r0_div_pending", 32'(bus.div_pending), 32'd1);
        cyc();
        chk("r0_buf_cleared", 32'(bus.div_pending), 32'd0);
        bus.dbg_valid = 1'b1; bus.dbg_waddr = 5'd0; bus.dbg_wdata = 32'h0000_0005;
        #1;
        chk("r0_dbg_ready", 32'(bus.dbg_ready), 32'd1);
        chk("r0_dbg_we", 32'(bus.we), 32'd0);
        cyc();
        bus.dbg_valid = 1'b0;

        // Reset while PEND with counter at 3
        bus.div_valid = 1'b1; bus.div_waddr = 5'd10; bus.div_wdata = 32'h0000_00AA;
        cyc();
        bus.div_valid = 1'b0;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd11; bus.wb_wdata = 32'h0000_00BB;
        for (int i = 0; i < 3; i++) cyc();
        chk("mid_cnt", 32'(starve_cnt), 32'd3);
        chk("mid_state", 32'(state), 32'(PEND));
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.we), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall_req), 32'd0);
        cyc();
        rst = 1'b0;
        bus.wb_we = 1'b0;
        #1;
        chk("mid_post_pending", 32'(bus.div_pending), 32'd0);
        chk("mid_post_cnt", 32'(starve_cnt), 32'd0);
        chk("mid_post_state", 32'(state), 32'(IDLE));
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_stall", 32'(bus.stall_req), 32'd0);
            chk("mid_no_r10", 32'(bus.we && (bus.waddr == 5'd10)), 32'd0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
